sd_audio_fetch: RTL and testbench

//  Sector fetch controller and word FIFO that sits downstream of the SD-card SPI single-block reader.
//  - Issues CMD17 read requests (rd_start_en / rd_sec_addr) for sectors start_sec .. start_sec+sec_num-1.
//  - Collects the 256 x 16-bit words each read returns; each read is 512 bytes.
//  - Byte-swaps each word to little-endian PCM and presents it to the audio output stage over a valid/ready handshake.

---
 rtl/sd_audio_fetch.sv | 174 +++++++++++++++++
 tb/tb_sd_audio_fetch.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_audio_fetch.sv
// rtl/sd_audio_fetch.sv - SD sector fetch controller with byte-swapping first-word-fall-through FIFO
// Optional feature macro: SKIP_HDR_EN (drop the 22-word WAV header after each playback start).
module sd_audio_fetch #(
  parameter int FIFO_AW = 10
) (
  input  logic               clk_ref,
  input  logic               rst_n,
  input  logic               play_en,
  input  logic [31:0]        start_sec,
  input  logic [31:0]        sec_num,
  input  logic               rd_busy,
  input  logic               rd_val_en,
  input  logic [15:0]        rd_val_data,
  output logic               rd_start_en,
  output logic [31:0]        rd_sec_addr,
  output logic [15:0]        aud_data,
  output logic               aud_valid,
  input  logic               aud_ready,
  output logic [FIFO_AW:0]   fifo_level,
  output logic               play_done,
  output logic               ovf_err
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] LVL_FULL    = (FIFO_AW+1)'(DEPTH);
  localparam logic [FIFO_AW:0] LVL_REQ_MAX = (FIFO_AW+1)'(DEPTH - 256);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_REQ,
    S_WAIT,
    S_FLUSH
  } state_t;

  state_t             state, state_nxt;
  logic               play_en_q;
  logic               play_rise;
  logic [31:0]        addr;
  logic [31:0]        remain;
  logic               load_req;
  logic               sec_done;
  logic               fifo_clr;
  logic               done_set;
  logic [15:0]        mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic               push_req;
  logic               push_ok;
  logic               pop;
  logic               skip_word;

  assign play_rise = play_en & ~play_en_q;

  always_comb begin
    state_nxt   = state;
    rd_start_en = 1'b0;
    load_req    = 1'b0;
    sec_done    = 1'b0;
    fifo_clr    = 1'b0;
    done_set    = 1'b0;
    case (state)
      S_IDLE: begin
        if (play_rise) state_nxt = S_CHECK;
      end
      S_CHECK: begin
        if (!play_en || remain == 32'd0) begin
          state_nxt = S_FLUSH;
        end else if (fifo_level <= LVL_REQ_MAX) begin
          load_req  = 1'b1;
          state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        rd_start_en = 1'b1;
        if (rd_busy) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (!rd_busy) begin
          sec_done  = 1'b1;
          state_nxt = S_CHECK;
        end
      end
      S_FLUSH: begin
        // A stop discards buffered audio; a normal end lets the consumer drain it.
        if (!play_en) begin
          fifo_clr  = 1'b1;
          done_set  = 1'b1;
          state_nxt = S_IDLE;
        end else if (fifo_level == '0) begin
          done_set  = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_ref or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      play_en_q   <= 1'b0;
      addr        <= 32'd0;
      remain      <= 32'd0;
      rd_sec_addr <= 32'd0;
      play_done   <= 1'b0;
    end else begin
      state     <= state_nxt;
      play_en_q <= play_en;
      play_done <= done_set;
      if (state == S_IDLE && play_rise) begin
        addr   <= start_sec;
        remain <= sec_num;
      end
      if (load_req) rd_sec_addr <= addr;
      if (sec_done) begin
        addr   <= addr + 32'd1;
        remain <= remain - 32'd1;
      end
    end
  end

`ifdef SKIP_HDR_EN
  logic [4:0] hdr_left;

  always_ff @(posedge clk_ref or negedge rst_n) begin
    if (!rst_n) begin
      hdr_left <= 5'd0;
    end else if (state == S_IDLE && play_rise) begin
      hdr_left <= 5'd22;
    end else if (rd_val_en && hdr_left != 5'd0) begin
      hdr_left <= hdr_left - 5'd1;
    end
  end

  assign skip_word = (hdr_left != 5'd0);
`else
  assign skip_word = 1'b0;
`endif

  assign pop       = aud_valid & aud_ready;
  assign push_req  = rd_val_en & ~skip_word;
  assign push_ok   = push_req & (fifo_level != LVL_FULL);
  assign aud_valid = (fifo_level != '0);
  assign aud_data  = aud_valid ? mem[rd_ptr] : 16'h0000;

  // Card byte order is big-endian per word; PCM wants little-endian.
  always_ff @(posedge clk_ref) begin
    if (push_ok) mem[wr_ptr] <= {rd_val_data[7:0], rd_val_data[15:8]};
  end

  always_ff @(posedge clk_ref or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      ovf_err    <= 1'b0;
    end else if (fifo_clr) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop)     rd_ptr <= rd_ptr + FIFO_AW'(1);
      if (push_req && !push_ok) ovf_err <= 1'b1;
      case ({push_ok, pop})
        2'b10:   fifo_level <= fifo_level + (FIFO_AW+1)'(1);
        2'b01:   fifo_level <= fifo_level - (FIFO_AW+1)'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_audio_fetch.sv
// tb/tb_sd_audio_fetch.sv - scoreboard bench for sd_audio_fetch with an SD reader model
module tb_sd_audio_fetch;

  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;
`ifdef SKIP_HDR_EN
  localparam int HDR = 22;
`else
  localparam int HDR = 0;
`endif

  logic          clk_ref;
  logic          rst_n;
  logic          play_en;
  logic [31:0]   start_sec;
  logic [31:0]   sec_num;
  logic          rd_busy;
  logic          rd_val_en;
  logic [15:0]   rd_val_data;
  logic          rd_start_en;
  logic [31:0]   rd_sec_addr;
  logic [15:0]   aud_data;
  logic          aud_valid;
  logic          aud_ready;
  logic [AW:0]   fifo_level;
  logic          play_done;
  logic          ovf_err;

  sd_audio_fetch #(.FIFO_AW(AW)) dut (
    .clk_ref     (clk_ref),
    .rst_n       (rst_n),
    .play_en     (play_en),
    .start_sec   (start_sec),
    .sec_num     (sec_num),
    .rd_busy     (rd_busy),
    .rd_val_en   (rd_val_en),
    .rd_val_data (rd_val_data),
    .rd_start_en (rd_start_en),
    .rd_sec_addr (rd_sec_addr),
    .aud_data    (aud_data),
    .aud_valid   (aud_valid),
    .aud_ready   (aud_ready),
    .fifo_level  (fifo_level),
    .play_done   (play_done),
    .ovf_err     (ovf_err)
  );

  initial clk_ref = 1'b0;
  always #5 clk_ref = ~clk_ref;

  int          n_chk = 0;
  int          n_pass = 0;
  logic [15:0] exp_q[$];
  logic [31:0] addr_q[$];
  int          req_cnt = 0;
  int          done_cnt = 0;
  int          pop_cnt = 0;
  int          start_cyc = 0;
  int          hdr_left = 0;
  bit          rand_ready = 0;
  bit          ready_lvl = 0;
  bit          gen_seq = 0;
  logic [7:0]  seq_byte = 8'd1;
  logic [15:0] first_sample = 16'h0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: a plain queue of byte-swapped words, with header skip and full-drop.
  task automatic model_push(logic [15:0] w);
    if (hdr_left > 0) hdr_left--;
    else if (exp_q.size() < DEPTH) exp_q.push_back({w[7:0], w[15:8]});
  endtask

  // Called in the phase 1 time unit after a rising edge; leaves in the same phase.
  task automatic drive_word(logic [15:0] w);
    rd_val_en   = 1'b1;
    rd_val_data = w;
    model_push(w);
    @(posedge clk_ref); #1;
    rd_val_en = 1'b0;
  endtask

  function automatic logic [15:0] next_word();
    logic [15:0] w;
    if (gen_seq) begin
      w = {seq_byte, seq_byte + 8'd1};
      seq_byte = seq_byte + 8'd2;
    end else begin
      w = 16'($urandom);
    end
    return w;
  endfunction

  // SD single-block reader model: one 256-word sector per request.
  initial begin
    rd_busy     = 1'b0;
    rd_val_en   = 1'b0;
    rd_val_data = 16'h0;
    forever begin
      @(negedge clk_ref);
      if (rst_n && rd_start_en && !rd_busy) begin
        req_cnt++;
        if (addr_q.size() == 0) check("req_expected", 64'(addr_q.size()), 64'd1);
        else check("req_addr", rd_sec_addr, addr_q.pop_front());
        @(posedge clk_ref); #1;
        rd_busy = 1'b1;
        repeat (2) @(posedge clk_ref);
        #1;
        for (int i = 0; i < 256; i++) begin
          if (!rst_n) break;
          if ($urandom_range(3) == 0) begin
            @(posedge clk_ref); #1;
          end
          drive_word(next_word());
        end
        rd_busy = 1'b0;
      end
    end
  end

  initial begin
    aud_ready = 1'b0;
    forever begin
      @(posedge clk_ref); #2;
      aud_ready = rand_ready ? 1'($urandom_range(1)) : ready_lvl;
    end
  end

  always @(negedge clk_ref) begin
    if (play_done) done_cnt++;
    if (rd_start_en) start_cyc++;
    if (rst_n && aud_valid && aud_ready) begin
      if (pop_cnt == 0) first_sample = aud_data;
      pop_cnt++;
      if (exp_q.size() == 0) check("sb_nonempty", 64'(exp_q.size()), 64'd1);
      else check("aud_data", aud_data, exp_q.pop_front());
    end
  end

  task automatic start_play(logic [31:0] s, logic [31:0] n, int nreq);
    for (int i = 0; i < nreq; i++) addr_q.push_back(s + 32'(i));
    hdr_left  = HDR;
    start_sec = s;
    sec_num   = n;
    play_en   = 1'b1;
    @(posedge clk_ref); #1;
  endtask

  task automatic wait_done(string name, int budget);
    int d0;
    int k;
    d0 = done_cnt;
    k  = 0;
    while (done_cnt == d0 && k < budget) begin
      @(posedge clk_ref); #1;
      k++;
    end
    repeat (5) @(posedge clk_ref);
    #1;
    check(name, 64'(done_cnt - d0), 64'd1);
  endtask

  task automatic drain(int budget);
    int k;
    k = 0;
    rand_ready = 1;
    while (fifo_level != 0 && k < budget) begin
      @(posedge clk_ref); #1;
      k++;
    end
    rand_ready = 0;
    @(posedge clk_ref); #1;
    check("drain_level", fifo_level, 0);
  endtask

  initial begin
    int k;
    int s0;
    rst_n     = 1'b0;
    play_en   = 1'b0;
    start_sec = 32'h0;
    sec_num   = 32'h0;
    repeat (3) @(posedge clk_ref);
    #1;
    check("reset_outputs",
          64'({rd_start_en, rd_sec_addr, aud_data, aud_valid, fifo_level, play_done, ovf_err}), 64'd0);
    rst_n = 1'b1;
    @(posedge clk_ref); #1;

    // Sequential card data, always-ready consumer, two sectors from 100.
    gen_seq = 1; ready_lvl = 1; req_cnt = 0; pop_cnt = 0;
    start_play(32'd100, 32'd2, 2);
    wait_done("t1_done_pulse", 6000);
    check("t1_req_cnt", req_cnt, 2);
    check("t1_samples", pop_cnt, 512 - HDR);
    check("t1_first_sample", first_sample, (HDR == 0) ? 16'h0201 : 16'h2e2d);
    check("t1_sb_empty", exp_q.size(), 0);
    play_en = 0; gen_seq = 0; ready_lvl = 0;
    repeat (3) @(posedge clk_ref);
    #1;

    // Stalled consumer: fetch must stop once the FIFO cannot take another sector.
    req_cnt = 0;
    start_play(32'd500, 32'd8, 4);
    k = 0;
    while (fifo_level != (AW+1)'(DEPTH - HDR) && k < 20000) begin
      @(posedge clk_ref); #1;
      k++;
    end
    s0 = start_cyc;
    repeat (300) @(posedge clk_ref);
    #1;
    check("t2_req_cnt", req_cnt, 4);
    check("t2_level", fifo_level, DEPTH - HDR);
    check("t2_level_model", fifo_level, exp_q.size());
    check("t2_no_more_start", start_cyc - s0, 0);
    check("t2_ovf", ovf_err, 0);
    play_en = 0;
    wait_done("t2_stop_done", 50);
    exp_q.delete();
    check("t2_flushed", fifo_level, 0);

    // Stop while the second of five sectors is being read.
    req_cnt = 0; rand_ready = 1;
    start_play(32'd2000, 32'd5, 2);
    k = 0;
    while (!(req_cnt == 2 && rd_busy) && k < 20000) begin
      @(posedge clk_ref); #1;
      k++;
    end
    play_en = 0;
    wait_done("t3_stop_done", 2000);
    rand_ready = 0;
    exp_q.delete();
    repeat (50) @(posedge clk_ref);
    #1;
    check("t3_req_cnt", req_cnt, 2);
    check("t3_level", fifo_level, 0);
    check("t3_valid", aud_valid, 0);
    check("t3_addr_q", addr_q.size(), 0);

    // Direct pushes while idle: simultaneous push/pop at 300, then overflow at full.
    for (int i = 0; i < 300; i++) drive_word(next_word());
    check("t4_level_300", fifo_level, 300);
    ready_lvl = 1;
    drive_word(next_word());
    ready_lvl = 0;
    @(posedge clk_ref); #1;
    check("t4_level_pushpop", fifo_level, 300);
    check("t4_level_model", fifo_level, exp_q.size());
    drain(3000);
    check("t4_ovf_before", ovf_err, 0);
    for (int i = 0; i < DEPTH; i++) drive_word(next_word());
    check("t4_full", fifo_level, DEPTH);
    check("t4_ovf_at_full", ovf_err, 0);
    drive_word(next_word());
    @(posedge clk_ref); #1;
    check("t4_ovf_set", ovf_err, 1);
    check("t4_level_held", fifo_level, DEPTH);
    drain(5000);
    check("t4_ovf_sticky", ovf_err, 1);
    check("t4_sb_empty", exp_q.size(), 0);

    // Zero-sector play: no request, play_done on the third edge after play_en rises.
    s0 = start_cyc; hdr_left = HDR;
    start_sec = 32'd9; sec_num = 32'd0; play_en = 1;
    @(posedge clk_ref); #1;
    check("t5_done_e1", play_done, 0);
    @(posedge clk_ref); #1;
    check("t5_done_e2", play_done, 0);
    @(posedge clk_ref); #1;
    check("t5_done_e3", play_done, 1);
    @(posedge clk_ref); #1;
    check("t5_done_e4", play_done, 0);
    check("t5_no_req", start_cyc - s0, 0);
    play_en = 0;
    @(posedge clk_ref); #1;

    // Asynchronous reset in the middle of a sector read.
    req_cnt = 0;
    start_play(32'd7, 32'd3, 3);
    k = 0;
    while (!(req_cnt == 1 && rd_busy) && k < 200) begin
      @(posedge clk_ref); #1;
      k++;
    end
    repeat (40) @(posedge clk_ref);
    #1;
    rst_n = 0; play_en = 0;
    #1;
    check("t5_reset_outputs",
          64'({rd_start_en, rd_sec_addr, aud_data, aud_valid, fifo_level, play_done, ovf_err}), 64'd0);
    repeat (5) @(posedge clk_ref);
    #1;
    exp_q.delete(); addr_q.delete(); hdr_left = 0;
    check("t5_reset_level", fifo_level, 0);
    rst_n = 1;
    @(posedge clk_ref); #1;

    // Address wrap from 32'hFFFFFFFF to 0 with a random consumer.
    req_cnt = 0; pop_cnt = 0; rand_ready = 1;
    start_play(32'hFFFF_FFFF, 32'd2, 2);
    wait_done("t6_done", 8000);
    check("t6_req_cnt", req_cnt, 2);
    check("t6_samples", pop_cnt, 512 - HDR);
    check("t6_sb_empty", exp_q.size(), 0);
    rand_ready = 0; play_en = 0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
